// File: rtl/mul_pkg.sv
// Shared widths, request op encodings and controller state encodings for the
// iterative multiplier front end.
package mul_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned MW   = XLEN + 2;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    RESP  = 2'b10,
    DRAIN = 2'b11
  } state_e;

endpackage

// File: rtl/mul_operand_ext.sv
// Decodes the op into per-operand signedness and widens both operands to the
// multiplier width (sign copy when signed, zero fill otherwise).
module mul_operand_ext #(
  parameter int unsigned XLEN = mul_pkg::XLEN,
  parameter int unsigned MW   = mul_pkg::MW
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_sa,
  output logic            o_sb,
  output logic [MW-1:0]   o_x,
  output logic [MW-1:0]   o_y
);
  import mul_pkg::*;

  always_comb begin
    o_sa = 1'b0;
    o_sb = 1'b0;
    case (op_e'(i_op))
      OP_MUL, OP_MULH: begin
        o_sa = 1'b1;
        o_sb = 1'b1;
      end
      OP_MULHSU: begin
        o_sa = 1'b1;
        o_sb = 1'b0;
      end
      default: begin
        o_sa = 1'b0;
        o_sb = 1'b0;
      end
    endcase
  end

  assign o_x = {{(MW-XLEN){o_sa & i_a[XLEN-1]}}, i_a};
  assign o_y = {{(MW-XLEN){o_sb & i_b[XLEN-1]}}, i_b};

endmodule

// File: rtl/mul_issue_ctrl.sv
// Front-end controller for the iterative Booth multiplier: request handshake,
// zero bypass, one-entry product cache, launch/wait, flush drain, response.
module mul_issue_ctrl #(
  parameter int unsigned XLEN = mul_pkg::XLEN,
  parameter int unsigned MW   = mul_pkg::MW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              mul_start,
  output logic [MW-1:0]     mul_x,
  output logic [MW-1:0]     mul_y,
  input  logic              mul_done,
  input  logic [2*MW-1:0]   mul_result
);
  import mul_pkg::*;

  localparam int unsigned PW = 2 * XLEN;

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_mask;
  logic [1:0]      r_op;
  logic            r_sa, r_sb;
  logic [MW-1:0]   r_x, r_y;
  logic            r_start;
  logic [XLEN-1:0] r_out, w_out_nxt;

  logic            r_c_valid;
  logic [XLEN-1:0] r_c_a, r_c_b;
  logic            r_c_sa, r_c_sb;
  logic [PW-1:0]   r_c_prod;

  logic            w_sa, w_sb;
  logic [MW-1:0]   w_x, w_y;
  logic            w_accept, w_zero, w_hit, w_launch, w_capture, w_mask_done;
  logic            w_unused_hi;

  function automatic logic [XLEN-1:0] sel_half(input logic [PW-1:0] p,
                                               input logic [1:0]    op);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  mul_operand_ext #(
    .XLEN (XLEN),
    .MW   (MW)
  ) u_ext (
    .i_op (in_op),
    .i_a  (in_a),
    .i_b  (in_b),
    .o_sa (w_sa),
    .o_sb (w_sb),
    .o_x  (w_x),
    .o_y  (w_y)
  );

  // Flush wins over a same-cycle request, so it gates acceptance.
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_zero      = (in_a == '0) || (in_b == '0);
  assign w_hit       = r_c_valid && (in_a == r_c_a) && (in_b == r_c_b) &&
                       ((in_op == OP_MUL) || ((w_sa == r_c_sa) && (w_sb == r_c_sb)));
  assign w_mask_done = (r_mask == 2'd0);
  assign w_unused_hi = ^mul_result[2*MW-1:PW];

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_zero) begin
            w_out_nxt   = '0;
            w_state_nxt = RESP;
          end else if (w_hit) begin
            w_out_nxt   = sel_half(r_c_prod, in_op);
            w_state_nxt = RESP;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          w_state_nxt = DRAIN;
        end else if (w_mask_done && mul_done) begin
          w_capture   = 1'b1;
          w_out_nxt   = sel_half(mul_result[PW-1:0], r_op);
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (flush || out_ready) w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (w_mask_done && mul_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_op      <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_start   <= 1'b0;
      r_out     <= '0;
      r_c_valid <= 1'b0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_sa    <= 1'b0;
      r_c_sb    <= 1'b0;
      r_c_prod  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_start <= w_launch;
      // Mask counts the start cycle and the one after; it keeps running into DRAIN.
      if (w_launch) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_op   <= in_op;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_mask <= 2'd2;
      end else if (!w_mask_done) begin
        r_mask <= r_mask - 2'd1;
      end
      if (w_capture) begin
        r_c_valid <= 1'b1;
        r_c_a     <= r_x[XLEN-1:0];
        r_c_b     <= r_y[XLEN-1:0];
        r_c_sa    <= r_sa;
        r_c_sb    <= r_sb;
        r_c_prod  <= mul_result[PW-1:0];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == RESP);
  assign out_data  = r_out;
  assign mul_start = r_start;
  assign mul_x     = r_x;
  assign mul_y     = r_y;

endmodule
